// File: rtl/clk_rst_seq_if.sv
// Status/control bundle between the MMCM reset sequencer and its user.
// The sequencer side is the slave.
interface clk_rst_seq_if #(
    parameter int RETRY_W = 2
);
    logic               i_mmcm_locked;
    logic               i_restart;
    logic               o_mmcm_reset;
    logic               o_sys_reset;
    logic               o_ready;
    logic               o_fail;
    logic               o_lock_lost;
    logic [RETRY_W-1:0] o_retry_cnt;
    logic [2:0]         o_state;

    modport master (
        output i_mmcm_locked, i_restart,
        input  o_mmcm_reset, o_sys_reset, o_ready, o_fail, o_lock_lost, o_retry_cnt, o_state
    );

    modport slave (
        input  i_mmcm_locked, i_restart,
        output o_mmcm_reset, o_sys_reset, o_ready, o_fail, o_lock_lost, o_retry_cnt, o_state
    );
endinterface

// File: rtl/clk_rst_seq.sv
// MMCM reset/lock sequencer: holds MMCM reset, waits for lock with timeout and
// bounded retries, and releases the system reset only after lock is stable.
module clk_rst_seq #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int RETRY_W             = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    clk_rst_seq_if.slave  seq
);
    localparam int MAX_HT  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_HT > LOCK_STABLE_CYCLES) ? MAX_HT : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [RETRY_W-1:0] retry, retry_nx;
    logic               lost_nx;
    logic               sync_q, locked_s;
    logic               mmcm_reset_q, sys_reset_q, ready_q, fail_q, lock_lost_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= seq.i_mmcm_locked;
            locked_s <= sync_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_HOLD_RST;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            retry <= retry_nx;
        end
    end

    always_comb begin
        state_nx = state;
        retry_nx = retry;
        lost_nx  = 1'b0;
        if (seq.i_restart) begin
            state_nx = ST_HOLD_RST;
            retry_nx = '0;
        end else begin
            case (state)
                ST_HOLD_RST: begin
                    if (cnt == HOLD_LAST) state_nx = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx = ST_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry == RETRY_LAST) begin
                            state_nx = ST_FAIL;
                        end else begin
                            state_nx = ST_HOLD_RST;
                            retry_nx = retry + RETRY_W'(1);
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s)                state_nx = ST_WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_nx = ST_HOLD_RST;
                        retry_nx = '0;
                        lost_nx  = 1'b1;
                    end
                end
                ST_FAIL: ;
                default: state_nx = ST_HOLD_RST;
            endcase
        end

        // Counter only runs in the timed states; any entry (or restart) clears it.
        cnt_nx = cnt;
        if (seq.i_restart || (state_nx != state))
            cnt_nx = '0;
        else if (state == ST_HOLD_RST || state == ST_WAIT_LOCK || state == ST_STABLE)
            cnt_nx = cnt + CNT_W'(1);
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register on the same edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mmcm_reset_q <= 1'b1;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            mmcm_reset_q <= (state_nx == ST_HOLD_RST) || (state_nx == ST_FAIL);
            sys_reset_q  <= (state_nx != ST_RUN);
            ready_q      <= (state_nx == ST_RUN);
            fail_q       <= (state_nx == ST_FAIL);
            lock_lost_q  <= lost_nx;
        end
    end

    assign seq.o_mmcm_reset = mmcm_reset_q;
    assign seq.o_sys_reset  = sys_reset_q;
    assign seq.o_ready      = ready_q;
    assign seq.o_fail       = fail_q;
    assign seq.o_lock_lost  = lock_lost_q;
    assign seq.o_retry_cnt  = retry;
    assign seq.o_state      = state;
endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Reset and lock sequencer for the MMCM clock generator.
- Runs on the free-running board clock (the MMCM input clock).
- Drives the MMCM reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the downstream system reset.
- If lock is lost during operation, it re-runs the full sequence. The AES core domain uses o_sys_reset (through its own synchronizer) and o_ready.

Parameters:
- RST_HOLD_CYCLES, 16: cycles o_mmcm_reset is held high per attempt; must be >= 1.
- LOCK_TIMEOUT_CYCLES, 65536: max cycles in WAIT_LOCK before the attempt fails; must be >= 2.
- LOCK_STABLE_CYCLES, 256: consecutive synced-lock cycles required before RUN; must be >= 1.
- MAX_RETRIES, 3: extra attempts after the first timeout before FAIL.
- RETRY_W, 2: width of o_retry_cnt; must satisfy 2**RETRY_W > MAX_RETRIES.

Ports:
- i_clk  input  1  free-running board clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_mmcm_locked  input  1  raw MMCM LOCKED, asynchronous to i_clk; 2-flop synchronized internally.
- i_restart  input  1  synchronous single-cycle pulse; forces a fresh sequence.
- o_mmcm_reset  output  1  active-high reset to the MMCM RST pin.
- o_sys_reset  output  1  active-high system reset; low only in RUN.
- o_ready  output  1  high only in RUN.
- o_fail  output  1  high only in FAIL.
- o_lock_lost  output  1  one-cycle pulse on the cycle RUN exits due to lock loss.
- o_retry_cnt  output  RETRY_W  timeouts in the current sequence.
- o_state  output  3  state code: HOLD_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- Reset (i_reset_n low, async):
  - state=HOLD_RST, counter=0, retry=0, sync flops=0.
  - o_mmcm_reset=1, o_sys_reset=1, o_ready=0, o_fail=0, o_lock_lost=0, o_retry_cnt=0.
- All outputs are flops. Each output equals the decode of the current state; no combinational paths to outputs.
- locked_s is i_mmcm_locked after 2 flops, so there is 2 cycles of latency.
- One shared cycle counter. It clears on every state change and is sized by $clog2 of the largest count parameter.
- HOLD_RST:
  - o_mmcm_reset=1.
  - Stays exactly RST_HOLD_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - o_mmcm_reset=0.
  - locked_s=1 -> STABLE.
  - Otherwise, when counter == LOCK_TIMEOUT_CYCLES-1:
    - if retry==MAX_RETRIES -> FAIL;
    - else retry+1 -> HOLD_RST.
  - If lock is seen on the timeout cycle, lock wins.
- STABLE:
  - locked_s=0 -> WAIT_LOCK with a fresh timeout; retry is unchanged.
  - After exactly LOCK_STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN.
- RUN:
  - o_sys_reset=0, o_ready=1.
  - locked_s=0 -> HOLD_RST, retry cleared to 0, o_lock_lost=1 for that one transition cycle.
  - o_sys_reset and o_ready return to 1 and 0 on the same edge.
- FAIL:
  - o_mmcm_reset=1, o_sys_reset=1, o_fail=1.
  - Stays until i_restart or i_reset_n.
- i_restart:
  - Top priority in every state, including over lock loss and timeout.
  - Next state HOLD_RST, counter=0, retry=0, o_fail=0.
  - A restart in HOLD_RST restarts the hold count.
  - o_lock_lost is not pulsed on restart.
- Timing checks:
  - First sequence after reset release: o_mmcm_reset high for exactly RST_HOLD_CYCLES rising edges.
  - From the first edge sampling i_mmcm_locked=1 while in WAIT_LOCK, o_ready rises exactly LOCK_STABLE_CYCLES+2 edges later.
- i_mmcm_locked glitches shorter than a cycle may or may not be captured. Any captured low drops STABLE or RUN as specified.
- o_retry_cnt never wraps. FAIL is entered with o_retry_cnt == MAX_RETRIES.
- Unused state codes (5-7) go to HOLD_RST on the next edge.

Test Plan:
All scenarios use RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal lock:
  - Stimulus: release reset; assert locked 10 cycles after o_mmcm_reset falls.
  - Required: o_mmcm_reset high 4 cycles; o_state 0->1->2->3; o_ready rises 10 edges after locked is first sampled; o_retry_cnt=0.
- Timeout and retries:
  - Stimulus: locked stays 0.
  - Required: three WAIT_LOCK windows of 32 cycles, each separated by 4-cycle resets; o_retry_cnt steps 0,1,2; FAIL entered with o_fail=1, o_mmcm_reset=1, o_retry_cnt=2.
- Restart from FAIL:
  - Stimulus: pulse i_restart while in FAIL.
  - Required: next cycle o_state=0, o_fail=0, o_retry_cnt=0; then a normal sequence completes to RUN.
- Unstable lock:
  - Stimulus: locked high 5 cycles, low 1 cycle, then high.
  - Required: STABLE->WAIT_LOCK->STABLE; o_ready rises only after 8 uninterrupted cycles; retry unchanged.
- Lock loss in RUN:
  - Stimulus: drop locked while in RUN.
  - Required: 2 cycles later o_lock_lost pulses for 1 cycle, o_sys_reset=1, o_ready=0, o_state=0, o_retry_cnt=0; full re-sequence follows.
- Async reset mid-STABLE and simultaneous events:
  - Stimulus: assert i_reset_n low during STABLE.
  - Required: outputs go to reset values immediately, without waiting for a clock edge.
  - Stimulus: assert i_restart on the same cycle as a WAIT_LOCK timeout.
  - Required: HOLD_RST with o_retry_cnt=0.
